// File: rtl/pal_sync_gen.sv
// PAL composite-sync and 8-bar colour pattern generator.
// Half-line counters drive sync-type decode and a bar counter; all outputs are registered.
module pal_sync_gen #(
  parameter int HALF_LINE = 320,
  parameter int HSYNC_W   = 47,
  parameter int EQ_W      = 23,
  parameter int BROAD_W   = 273,
  parameter int ACT_X0    = 120,
  parameter int BAR_W     = 65,
  parameter int ACT_HL0   = 46,
  parameter int ACT_HL1   = 622,
  parameter int FIELD_HL  = 625
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  output logic [2:0] r,
  output logic [2:0] g,
  output logic [2:0] b,
  output logic       csync,
  output logic       field,
  output logic       frame_start
);
  localparam int HCW = $clog2(HALF_LINE);
  localparam int HLW = $clog2(FIELD_HL);
  localparam int BPW = $clog2(BAR_W);

  typedef enum logic [1:0] {SYNC_EQ, SYNC_BROAD, SYNC_LINE, SYNC_NONE} sync_t;

  logic [HCW-1:0] hc;
  logic [HLW-1:0] hl;
  logic           field_r;
  logic           mode_r;
  logic [BPW-1:0] bar_pos;
  logic [2:0]     bar_idx;

  logic  hc_last;
  logic  hl_last;
  logic  line_start;
  logic  next_field;
  sync_t sync_kind;
  logic  sync_low;
  logic  active;
  logic  fs_now;

  always_comb begin
    hc_last    = (hc == HCW'(HALF_LINE - 1));
    hl_last    = mode_r ? (hl == HLW'(FIELD_HL - 2)) : (hl == HLW'(FIELD_HL - 1));
    // A half-line begins a full line when its parity matches the field.
    line_start = (hl[0] == field_r);
    next_field = mode_r ? 1'b0 : ~field_r;

    sync_kind = SYNC_NONE;
    if (hl < HLW'(5))       sync_kind = SYNC_EQ;
    else if (hl < HLW'(10)) sync_kind = SYNC_BROAD;
    else if (hl < HLW'(15)) sync_kind = SYNC_EQ;
    else if (line_start)    sync_kind = SYNC_LINE;

    sync_low = 1'b0;
    case (sync_kind)
      SYNC_EQ:    sync_low = (hc < HCW'(EQ_W));
      SYNC_BROAD: sync_low = (hc < HCW'(BROAD_W));
      SYNC_LINE:  sync_low = (hc < HCW'(HSYNC_W));
      default:    sync_low = 1'b0;
    endcase

    // Second-half half-lines sit at x >= HALF_LINE, always past ACT_X0.
    active = (hl >= HLW'(ACT_HL0)) && (hl < HLW'(ACT_HL1)) &&
             (!line_start || (hc >= HCW'(ACT_X0)));
    fs_now = (hc == '0) && (hl == '0) && !field_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hc      <= '0;
      hl      <= '0;
      field_r <= 1'b0;
      mode_r  <= mode;
      bar_pos <= '0;
      bar_idx <= '0;
    end else begin
      if (hc_last) begin
        hc <= '0;
        if (hl_last) begin
          hl      <= '0;
          field_r <= next_field;
          if (!next_field) mode_r <= mode;
        end else begin
          hl <= hl + 1'b1;
        end
      end else begin
        hc <= hc + 1'b1;
      end

      // Bar counter restarts just before the first active clk of every line.
      if (line_start && (hc == HCW'(ACT_X0 - 1))) begin
        bar_pos <= '0;
        bar_idx <= '0;
      end else if (bar_pos == BPW'(BAR_W - 1)) begin
        bar_pos <= '0;
        bar_idx <= bar_idx + 1'b1;
      end else begin
        bar_pos <= bar_pos + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csync       <= 1'b1;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      field       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      csync       <= ~sync_low;
      r           <= {3{active & ~bar_idx[1]}};
      g           <= {3{active & ~bar_idx[2]}};
      b           <= {3{active & ~bar_idx[0]}};
      field       <= field_r;
      frame_start <= fs_now;
    end
  end
endmodule

// File: tb/tb_pal_sync_gen.sv
// Self-checking bench: full-size instance for sync/bar timing, reduced instance
// (short half-lines, short fields) for frame, field and mode-switch behaviour.
module tb_pal_sync_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_f, mode_f, rst_s, mode_s;
  logic [2:0] r_f, g_f, b_f, r_s, g_s, b_s;
  logic       cs_f, fld_f, fs_f, cs_s, fld_s, fs_s;

  pal_sync_gen dut_f (
    .clk(clk), .rst(rst_f), .mode(mode_f), .r(r_f), .g(g_f), .b(b_f),
    .csync(cs_f), .field(fld_f), .frame_start(fs_f)
  );

  // Small instance: 32 clk half-lines, 41 half-line interlaced fields.
  pal_sync_gen #(
    .HALF_LINE(32), .HSYNC_W(5), .EQ_W(2), .BROAD_W(27), .ACT_X0(12),
    .BAR_W(6), .ACT_HL0(20), .ACT_HL1(36), .FIELD_HL(41)
  ) dut_s (
    .clk(clk), .rst(rst_s), .mode(mode_s), .r(r_s), .g(g_s), .b(b_s),
    .csync(cs_s), .field(fld_s), .frame_start(fs_s)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int fs_q[$];
  int fe_q[$];
  int fld_hi, lo_a, lo_b, cs_at_fall;

  typedef struct {
    int         hl;
    int         hc;
    logic       cs;
    logic [8:0] rgb;
  } vec_t;

  vec_t tv[24];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  function automatic int exp_low(input int h);
    if (h < 5)  return 23;
    if (h < 10) return 273;
    if (h < 15) return 23;
    return (h % 2 == 0) ? 47 : 0;
  endfunction

  task automatic reset_full(input logic m);
    rst_f  = 1'b1;
    mode_f = m;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_csync", int'(cs_f), 1);
      chk("rst_rgb", int'({r_f, g_f, b_f}), 0);
    end
    rst_f = 1'b0;
    cyc   = 0;
  endtask

  // Runs the small instance n clk after reset, logging frame_start and field edges.
  task automatic run_small(input logic m0, input int n, input int sw_at);
    logic prev_fld;
    rst_s  = 1'b1;
    mode_s = m0;
    step();
    step();
    chk("s_rst_fs", int'(fs_s), 0);
    chk("s_rst_field", int'(fld_s), 0);
    rst_s = 1'b0;
    cyc   = 0;
    fs_q.delete();
    fe_q.delete();
    fld_hi = 0; lo_a = 0; lo_b = 0; cs_at_fall = -1;
    prev_fld = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (cyc == sw_at) mode_s = ~mode_s;
      step();
      if (fs_s) fs_q.push_back(cyc);
      if (fld_s != prev_fld) fe_q.push_back(cyc);
      prev_fld = fld_s;
      if (fld_s) fld_hi++;
      if (cyc >= 1825 && cyc <= 1856 && !cs_s) lo_a++;
      if (cyc >= 1857 && cyc <= 1888 && !cs_s) lo_b++;
      if (cyc == 1857) cs_at_fall = int'(cs_s);
    end
  endtask

  task automatic chk_q(input string name, input int q[$], input int exp[$]);
    chk({name, "_count"}, q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk(name, (i < q.size()) ? q[i] : -1, exp[i]);
  endtask

  initial begin
    int lows, nz;
    int target;
    rst_f = 1'b1; mode_f = 1'b1; rst_s = 1'b1; mode_s = 1'b1;

    tv[0]  = '{0,   0,   1'b0, 9'o000};
    tv[1]  = '{0,   22,  1'b0, 9'o000};
    tv[2]  = '{0,   23,  1'b1, 9'o000};
    tv[3]  = '{1,   0,   1'b0, 9'o000};
    tv[4]  = '{5,   272, 1'b0, 9'o000};
    tv[5]  = '{5,   273, 1'b1, 9'o000};
    tv[6]  = '{10,  22,  1'b0, 9'o000};
    tv[7]  = '{10,  23,  1'b1, 9'o000};
    tv[8]  = '{15,  0,   1'b1, 9'o000};
    tv[9]  = '{16,  46,  1'b0, 9'o000};
    tv[10] = '{16,  47,  1'b1, 9'o000};
    tv[11] = '{17,  0,   1'b1, 9'o000};
    tv[12] = '{45,  200, 1'b1, 9'o000};
    tv[13] = '{46,  0,   1'b0, 9'o000};
    tv[14] = '{46,  119, 1'b1, 9'o000};
    tv[15] = '{46,  120, 1'b1, 9'o777};
    tv[16] = '{46,  184, 1'b1, 9'o777};
    tv[17] = '{46,  185, 1'b1, 9'o770};
    tv[18] = '{46,  250, 1'b1, 9'o077};
    tv[19] = '{47,  0,   1'b1, 9'o070};
    tv[20] = '{47,  254, 1'b1, 9'o007};
    tv[21] = '{47,  255, 1'b1, 9'o000};
    tv[22] = '{47,  319, 1'b1, 9'o000};
    tv[23] = '{48,  0,   1'b0, 9'o000};

    // Reset, then per-half-line sync low counts for hl 0..17.
    reset_full(1'b1);
    step();
    chk("first_eq_low", int'(cs_f), 0);
    lows = 1; nz = 0;
    for (int h = 0; h < 18; h++) begin
      for (int c = (h == 0) ? 1 : 0; c < 320; c++) begin
        step();
        if (!cs_f) lows++;
        if ({r_f, g_f, b_f} != 9'o000) nz++;
      end
      chk($sformatf("low_clks_hl%0d", h), lows, exp_low(h));
      lows = 0;
    end
    chk("rgb_blank_hl0_17", nz, 0);

    // Vector table: output at clk n after release reflects position n-1.
    reset_full(1'b1);
    for (int i = 0; i < 24; i++) begin
      target = tv[i].hl * 320 + tv[i].hc + 1;
      while (cyc < target) step();
      chk($sformatf("v%0d_csync", i), int'(cs_f), int'(tv[i].cs));
      chk($sformatf("v%0d_rgb", i), int'({r_f, g_f, b_f}), int'(tv[i].rgb));
    end
    lows = 0;
    for (int c = 0; c < 640; c++) begin
      step();
      if (!cs_f) lows++;
    end
    chk("line_low_per_640", lows, 47);
    rst_f = 1'b1;

    // Progressive: 40 half-lines x 32 clk per frame, field stays 0.
    run_small(1'b1, 2700, -1);
    chk_q("prog_fs", fs_q, '{1, 1281, 2561});
    chk("prog_field_high_clks", fld_hi, 0);

    // Interlaced: 41 half-lines per field, field 1 starts mid-line.
    run_small(1'b0, 5300, -1);
    chk_q("intl_fs", fs_q, '{1, 2625, 5249});
    chk_q("intl_field_edge", fe_q, '{1313, 2625, 3937, 5249});
    chk("f1_midline_lows", lo_a, 0);
    chk("f1_hsync_lows", lo_b, 5);
    chk("f1_hsync_fall", cs_at_fall, 0);

    // Mode 0->1 mid field 0: frame completes interlaced, then progressive.
    run_small(1'b0, 5300, 200);
    chk_q("switch_fs", fs_q, '{1, 2625, 3905, 5185});
    chk_q("switch_field_edge", fe_q, '{1313, 2625});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
